// File: rtl/rex_game_ctrl_if.sv
// ----------------------------------------------------------------------------
// rex_game_ctrl_if
// Bundles the game-logic stage's frame/button inputs and its state outputs.
//   frame_tick    : one-cycle pulse per frame update          (master -> slave)
//   btn_jump      : raw jump/start button level, asynchronous (master -> slave)
//   rex_down      : Rex bottom y, unsigned, 0 = ground        (slave -> master)
//   obstacle_left : obstacle left x, two's-complement signed  (slave -> master)
//   game_state    : 0 = IDLE, 1 = RUN, 2 = OVER               (slave -> master)
//   score         : obstacles cleared, wrapping 16-bit count  (slave -> master)
// ----------------------------------------------------------------------------
interface rex_game_ctrl_if;
    logic        frame_tick;
    logic        btn_jump;
    logic [15:0] rex_down;
    logic [15:0] obstacle_left;
    logic [1:0]  game_state;
    logic [15:0] score;

    modport master (
        output frame_tick,
        output btn_jump,
        input  rex_down,
        input  obstacle_left,
        input  game_state,
        input  score
    );

    modport slave (
        input  frame_tick,
        input  btn_jump,
        output rex_down,
        output obstacle_left,
        output game_state,
        output score
    );
endinterface

// File: rtl/rex_game_ctrl.sv
// ----------------------------------------------------------------------------
// rex_game_ctrl
// Game-logic stage: Rex jump physics, obstacle scroll, collision detection and
// the IDLE/RUN/OVER state machine. Positions advance once per frame_tick.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : rex_game_ctrl_if.slave (frame_tick, btn_jump in;
//          rex_down, obstacle_left, game_state, score out, all registered)
// ----------------------------------------------------------------------------
module rex_game_ctrl #(
    parameter int JUMP_V    = 7,
    parameter int GRAVITY   = 1,
    parameter int MAX_H     = 41,
    parameter int OBS_START = 128,
    parameter int OBS_SPEED = 2
) (
    input  logic           clk,
    input  logic           rst,
    rex_game_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam logic signed [7:0]  JUMP_V_C    = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAVITY_C   = 8'(GRAVITY);
    localparam logic signed [17:0] MAX_H_S     = 18'(MAX_H);
    localparam logic [15:0]        MAX_H_U     = 16'(MAX_H);
    localparam logic signed [15:0] OBS_START_C = 16'(OBS_START);
    localparam logic signed [16:0] OBS_SPEED_C = 17'(OBS_SPEED);

    state_t             state_r, state_s;
    logic [15:0]        rex_down_r, rex_down_s;
    logic signed [7:0]  vel_r, vel_s;
    logic signed [15:0] obstacle_left_r, obstacle_left_s;
    logic [15:0]        score_r, score_s;
    logic               jump_req_r, jump_req_s;
    logic               sync1_r, sync2_r, btn_prev_r;

    logic               press_evt_s;
    logic               collide_s;
    logic               grounded_s;
    logic signed [7:0]  vel_eff_s;
    logic signed [17:0] h_s;
    logic signed [16:0] n_s;

    // Button synchronizer plus previous-level flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            btn_prev_r <= 1'b0;
        end else begin
            sync1_r    <= bus.btn_jump;
            sync2_r    <= sync1_r;
            btn_prev_r <= sync2_r;
        end
    end

    assign press_evt_s = sync2_r & ~btn_prev_r;

    // Obstacle box x[left,left+16) overlaps Rex x[8,32) and Rex y-box reaches y<22
    assign collide_s = (state_r == ST_RUN)
                     && (obstacle_left_r < 16'sd32)
                     && (obstacle_left_r > -16'sd8)
                     && (rex_down_r < 16'd22);

    // A buffered jump only launches from rest on the ground
    assign grounded_s = (rex_down_r == 16'd0) && (vel_r == 8'sd0);
    assign vel_eff_s  = (jump_req_r && grounded_s) ? JUMP_V_C : vel_r;
    assign h_s        = $signed({2'b00, rex_down_r}) + $signed({{10{vel_eff_s[7]}}, vel_eff_s});
    assign n_s        = $signed({obstacle_left_r[15], obstacle_left_r}) - OBS_SPEED_C;

    // State and game registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rex_down_r      <= 16'd0;
            vel_r           <= 8'sd0;
            obstacle_left_r <= OBS_START_C;
            score_r         <= 16'd0;
            jump_req_r      <= 1'b0;
        end else begin
            state_r         <= state_s;
            rex_down_r      <= rex_down_s;
            vel_r           <= vel_s;
            obstacle_left_r <= obstacle_left_s;
            score_r         <= score_s;
            jump_req_r      <= jump_req_s;
        end
    end

    // Next-state, physics and obstacle update
    always_comb begin
        state_s         = state_r;
        rex_down_s      = rex_down_r;
        vel_s           = vel_r;
        obstacle_left_s = obstacle_left_r;
        score_s         = score_r;
        jump_req_s      = jump_req_r;
        case (state_r)
            ST_IDLE: begin
                if (press_evt_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (collide_s) begin
                    // A tick arriving together with the hit is dropped
                    state_s = ST_OVER;
                end else if (bus.frame_tick) begin
                    if (h_s <= 18'sd0) begin
                        rex_down_s = 16'd0;
                        vel_s      = 8'sd0;
                    end else if (h_s >= MAX_H_S) begin
                        rex_down_s = MAX_H_U;
                        vel_s      = (vel_eff_s > 8'sd0) ? 8'sd0 : (vel_eff_s - GRAVITY_C);
                    end else begin
                        rex_down_s = h_s[15:0];
                        vel_s      = vel_eff_s - GRAVITY_C;
                    end
                    if (n_s <= -17'sd16) begin
                        obstacle_left_s = OBS_START_C;
                        score_s         = score_r + 16'd1;
                    end else begin
                        obstacle_left_s = n_s[15:0];
                    end
                    // Old request is consumed now; a press in this same cycle waits for the next tick
                    jump_req_s = press_evt_s;
                end else if (press_evt_s) begin
                    jump_req_s = 1'b1;
                end else begin
                    jump_req_s = jump_req_r;
                end
            end
            ST_OVER: begin
                if (press_evt_s) begin
                    state_s         = ST_RUN;
                    rex_down_s      = 16'd0;
                    vel_s           = 8'sd0;
                    obstacle_left_s = OBS_START_C;
                    score_s         = 16'd0;
                    jump_req_s      = 1'b0;
                end else begin
                    state_s = ST_OVER;
                end
            end
            ST_BAD: begin
                state_s         = ST_IDLE;
                rex_down_s      = 16'd0;
                vel_s           = 8'sd0;
                obstacle_left_s = OBS_START_C;
                score_s         = 16'd0;
                jump_req_s      = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.rex_down      = rex_down_r;
    assign bus.obstacle_left = obstacle_left_r;
    assign bus.game_state    = state_r;
    assign bus.score         = score_r;

endmodule

// File: tb/tb_rex_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rex_game_ctrl
// Drives a default-parameter instance (a) and a JUMP_V=8/OBS_SPEED=8 instance
// (b) with directed scenarios and random stimulus, comparing every cycle
// against a behavioural game model.
// ----------------------------------------------------------------------------
module tb_rex_game_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rex_game_ctrl_if ifa();
    rex_game_ctrl_if ifb();

    rex_game_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    rex_game_ctrl #(.JUMP_V(8), .OBS_SPEED(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        int rex;
        int vel;
        int obs;
        int st;
        int score;
        bit jreq;
        bit b1, b2, b3;   // button as sampled 1, 2 and 3 edges ago
    } mdl_t;

    mdl_t ma, mb;
    bit   btn_a, btn_b;
    int   errs   = 0;
    int   checks = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.rex = 0; m.vel = 0; m.obs = 128; m.st = 0; m.score = 0;
        m.jreq = 1'b0; m.b1 = 1'b0; m.b2 = 1'b0; m.b3 = 1'b0;
        return m;
    endfunction

    // One clock edge of the game rules
    function automatic mdl_t mdl_step(mdl_t m, bit tick, bit btn, int jv, int spd);
        bit evt;
        int ve, h, n;
        evt  = m.b2 && !m.b3;
        m.b3 = m.b2; m.b2 = m.b1; m.b1 = btn;
        if (m.st == 0) begin
            if (evt) m.st = 1;
        end else if (m.st == 1) begin
            if (m.obs < 32 && m.obs > -8 && m.rex < 22) begin
                m.st = 2;
            end else if (tick) begin
                ve = (m.jreq && m.rex == 0 && m.vel == 0) ? jv : m.vel;
                h  = m.rex + ve;
                if (h <= 0) begin
                    m.rex = 0; m.vel = 0;
                end else if (h >= 41) begin
                    m.rex = 41; m.vel = (ve > 0) ? 0 : ve - 1;
                end else begin
                    m.rex = h; m.vel = ve - 1;
                end
                n = m.obs - spd;
                if (n <= -16) begin
                    m.obs = 128; m.score = (m.score + 1) % 65536;
                end else begin
                    m.obs = n;
                end
                m.jreq = evt;
            end else if (evt) begin
                m.jreq = 1'b1;
            end
        end else begin
            if (evt) begin
                m.st = 1; m.rex = 0; m.vel = 0; m.obs = 128; m.score = 0; m.jreq = 1'b0;
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("a.rex",   int'(ifa.rex_down),               ma.rex);
        check("a.obs",   int'($signed(ifa.obstacle_left)), ma.obs);
        check("a.state", int'(ifa.game_state),             ma.st);
        check("a.score", int'(ifa.score),                  ma.score);
        check("b.rex",   int'(ifb.rex_down),               mb.rex);
        check("b.obs",   int'($signed(ifb.obstacle_left)), mb.obs);
        check("b.state", int'(ifb.game_state),             mb.st);
        check("b.score", int'(ifb.score),                  mb.score);
    endtask

    // Apply inputs, take one edge, advance models, compare just after the edge
    task automatic cycle(input bit tk);
        ifa.frame_tick = tk; ifb.frame_tick = tk;
        ifa.btn_jump   = btn_a; ifb.btn_jump = btn_b;
        @(posedge clk);
        if (rst) begin
            ma = mdl_reset(); mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, tk, btn_a, 7, 2);
            mb = mdl_step(mb, tk, btn_b, 8, 8);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    int arc_exp[15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
    int wrap_obs[8] = '{48, 40, 32, 24, 16, 8, 0, -8};
    int wrap_rex[8] = '{8, 15, 21, 26, 30, 33, 35, 36};
    bit found;

    initial begin
        rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
        ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0;
        ifa.btn_jump = 1'b0; ifb.btn_jump = 1'b0;
        ma = mdl_reset(); mb = mdl_reset();
        idle(2);
        rst = 1'b0;

        // Start b, jump to rex_down=15, then reset asynchronously mid-cycle
        btn_b = 1'b1; idle(3);
        check("b.start", int'(ifb.game_state), 1);
        btn_b = 1'b0; idle(2);
        btn_b = 1'b1; idle(3);
        cycle(1'b1); cycle(1'b1);
        check("b.rex15", int'(ifb.rex_down), 15);
        #3 rst = 1'b1;
        #1;
        ma = mdl_reset(); mb = mdl_reset();
        check("rst.rex",   int'(ifb.rex_down), 0);
        check("rst.obs",   int'($signed(ifb.obstacle_left)), 128);
        check("rst.state", int'(ifb.game_state), 0);
        check("rst.score", int'(ifb.score), 0);
        btn_b = 1'b0;
        cycle(1'b0);
        rst = 1'b0;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        check("idle.tick", int'($signed(ifb.obstacle_left)), 128);

        // Start a: RUN exactly three edges after the button rises
        btn_a = 1'b1; idle(2);
        check("a.start2", int'(ifa.game_state), 0);
        cycle(1'b0);
        check("a.start3", int'(ifa.game_state), 1);
        cycle(1'b1);
        check("a.first.obs", int'($signed(ifa.obstacle_left)), 126);
        check("a.first.rex", int'(ifa.rex_down), 0);

        // Jump arc with a second press buffered while airborne before tick 3
        btn_a = 1'b0; idle(2);
        btn_a = 1'b1; idle(3);
        for (int i = 0; i < 15; i++) begin
            if (i == 1) btn_a = 1'b0;
            if (i == 2) btn_a = 1'b1;
            idle(5);
            cycle(1'b1);
            check($sformatf("arc%0d", i), int'(ifa.rex_down), arc_exp[i]);
        end
        cycle(1'b1);
        check("arc.rest", int'(ifa.rex_down), 0);

        // Ground-level collision at obstacle_left=30
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(1'b1);
            if ($signed(ifa.obstacle_left) == 16'sd30) found = 1'b1;
        end
        check("coll.found", int'(found), 1);
        cycle(1'b1);
        check("coll.state", int'(ifa.game_state), 2);
        check("coll.obs",   int'($signed(ifa.obstacle_left)), 30);
        cycle(1'b1); cycle(1'b1);
        check("over.obs", int'($signed(ifa.obstacle_left)), 30);
        check("over.rex", int'(ifa.rex_down), 0);

        // b clears an obstacle in mid-air and the score increments
        btn_b = 1'b1; idle(3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1);
            if ($signed(ifb.obstacle_left) == 16'sd56) found = 1'b1;
        end
        check("wrap.found", int'(found), 1);
        btn_b = 1'b0; idle(2);
        btn_b = 1'b1; idle(3);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            check($sformatf("wrap.obs%0d", i), int'($signed(ifb.obstacle_left)), wrap_obs[i]);
            check($sformatf("wrap.rex%0d", i), int'(ifb.rex_down), wrap_rex[i]);
        end
        cycle(1'b1);
        check("wrap.reload", int'($signed(ifb.obstacle_left)), 128);
        check("wrap.score",  int'(ifb.score), 1);
        check("wrap.state",  int'(ifb.game_state), 1);

        // Restart a from OVER, then a press landing on the same edge as a tick
        btn_a = 1'b0; idle(2);
        btn_a = 1'b1; idle(3);
        check("restart.state", int'(ifa.game_state), 1);
        check("restart.obs",   int'($signed(ifa.obstacle_left)), 128);
        check("restart.score", int'(ifa.score), 0);
        btn_a = 1'b0; idle(2);
        btn_a = 1'b1; idle(2);
        cycle(1'b1);
        check("simul.now", int'(ifa.rex_down), 0);
        cycle(1'b0);
        cycle(1'b1);
        check("simul.next", int'(ifa.rex_down), 7);

        // Random play with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_a = ~btn_a;
            if ($urandom_range(0, 7) == 0) btn_b = ~btn_b;
            rst = ($urandom_range(0, 599) == 0);
            cycle($urandom_range(0, 3) == 0);
        end
        rst = 1'b0;
        cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rex_game_ctrl.md
Name: rex_game_ctrl

Overview:
- Game-logic stage directly upstream of the pixel decider; owns the Rex physics, obstacle scroll, collision detection and the game state machine.
- Produces rex_down, obstacle_left and game_state, which the decider consumes combinationally while the display driver scans.
- Updates positions once per frame_tick; everything else is held between ticks.

Parameters:
- JUMP_V, 7: initial upward velocity in px/tick.
- GRAVITY, 1: velocity decrement per tick.
- MAX_H, 41: rex_down ceiling (64 minus rex height 23).
- OBS_START, 128: obstacle_left reload value (right screen edge).
- OBS_SPEED, 2: px per tick leftward scroll.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame update
- btn_jump  in  1  raw jump/start button level, asynchronous to clk
- rex_down  out  16  Rex bottom y, unsigned, 0 = ground
- obstacle_left  out  16  obstacle left x, two's-complement signed
- game_state  out  2  0 = IDLE, 1 = RUN, 2 = OVER
- score  out  16  obstacles cleared, wraps at 65535→0

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-high.
  - Reset values: rex_down=0, vel=0, obstacle_left=OBS_START, game_state=IDLE, score=0, jump_req=0, sync flops=0.
- Button path:
  - 2-flop synchronizer, then rising-edge detect, giving press_evt 3 clk after the input rises.
  - Level held high gives a single press_evt.
- Jump buffering:
  - In RUN, press_evt sets jump_req.
  - jump_req is consumed and cleared at the next frame_tick.
  - If Rex is airborne at that tick (rex_down≠0 or vel≠0), the request is discarded. No queueing beyond one request.
- State machine:
  - IDLE: press_evt → RUN. Positions stay at their reset values.
  - RUN: physics runs on frame_tick. A collision detected in any cycle → OVER the next cycle; a tick in that same cycle is ignored.
  - OVER: all outputs frozen. press_evt → RUN and reinitialises rex_down=0, vel=0, obstacle_left=OBS_START, score=0, jump_req=0.
  - Encoding 3 → IDLE on the next clk.
- Physics, on each frame_tick in RUN (vel is 8-bit signed):
  - Consumed jump while grounded: vel_eff=JUMP_V; otherwise vel_eff=vel.
  - h = rex_down + vel_eff, computed signed.
  - h ≤ 0: rex_down=0, vel=0.
  - h ≥ MAX_H: rex_down=MAX_H, vel=0 when vel_eff>0.
  - Otherwise: rex_down=h, vel=vel_eff−GRAVITY.
- Obstacle, on each frame_tick in RUN:
  - n = obstacle_left − OBS_SPEED, signed.
  - n ≤ −16: obstacle_left=OBS_START and score+1 in the same cycle.
  - Otherwise: obstacle_left=n.
- Collision:
  - Combinational on registered values, RUN only.
  - Asserted when obstacle_left <s 32 AND obstacle_left >s −8 AND rex_down < 22.
  - This matches Rex box x[8,32) × y[rex_down, rex_down+23) against obstacle box x[left, left+16) × y[0,22).
- Timing:
  - All outputs are registered.
  - Updates become visible the cycle after frame_tick.

Test Plan:
- Reset: assert rst mid-RUN with rex_down=15 → outputs are immediately 0 / 128 / IDLE / 0; frame_tick is ignored while in IDLE.
- Start: raise btn_jump in IDLE → game_state=1 three clk later. First frame_tick → obstacle_left=126, rex_down=0.
- Jump arc: in RUN, with the obstacle far away, press, then apply 15 frame_ticks → rex_down sequence 7,13,18,22,25,27,28,28,27,25,22,18,13,7,0, ending with vel=0. A second press at tick 3 is discarded.
- Collision: defaults, no jump → at the tick where obstacle_left becomes 30, game_state=2 on the next clk; further frame_ticks leave rex_down=0 and obstacle_left=30.
- Clear and wrap:
  - Setup: OBS_SPEED=8, JUMP_V=8; press while obstacle_left=56.
  - Expected (left,rex) pairs: (48,8), (40,15), (32,21), (24,26), (16,30), (8,33), (0,35), (−8,36).
  - Next tick → obstacle_left=128, score=1, game_state stays RUN.
- Restart and simultaneity: press in OVER → RUN with all state reinitialised. A press_evt coinciding with a frame_tick in RUN → jump_req is set and consumed at the following tick, not the current one.
